stopwatch_control: RTL and testbench

Front-end controller for the stopwatch datapath. Turns two raw push-buttons (start/stop, clear) into clean control. Drives the `enable` input of the decimal second counter with a one-cycle tick once per tenth of a second while running. Drives that counter's clear with a one-cycle pulse. Sits directly upstream of the counter: its `enable` feeds the counter's `enable`, and its `clr` is ORed with the inverted system reset into the counter's active-high `reset`.

---
 rtl/stopwatch_control.sv | 154 +++++++++++++++
 tb/tb_stopwatch_control.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_control.sv
// Purpose: debounces the start/stop and clear buttons and runs the IDLE/RUN/PAUSE control for the stopwatch counter.
// Latency: a press takes DEBOUNCE+2 edges to change state; enable ticks every CLK_DIV cycles in RUN; clr is one registered cycle.
// Backpressure: none; the downstream counter consumes enable/clr every cycle and buttons are sampled continuously.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   btn_ss   raw start/stop button, active-high, asynchronous to clk
//   btn_clr  raw clear button, active-high, asynchronous to clk
//   enable   one-cycle count tick (combinational decode of RUN and prescaler terminal value)
//   clr      one-cycle registered clear pulse to the counter
//   running  registered decode of state RUN
module stopwatch_control #(
    parameter int CLK_DIV  = 5000000,
    parameter int DEBOUNCE = 200000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_ss,
    input  logic btn_clr,
    output logic enable,
    output logic clr,
    output logic running
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_clr, btn_ss};

    // One synchronizer + debouncer + rising-edge detector per button.
    // Bit 0 is start/stop, bit 1 is clear.
    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic          s1;
        logic          s2;
        logic          level;
        logic          level_q;
        logic [DW-1:0] db_cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1      <= 1'b0;
                s2      <= 1'b0;
                level   <= 1'b0;
                level_q <= 1'b0;
                db_cnt  <= '0;
            end else begin
                s1      <= btn_raw[g];
                s2      <= s1;
                level_q <= level;
                if (s2 == level) begin
                    // Any agreement with the accepted level restarts the
                    // stability count, so glitches never accumulate.
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    // This edge would make the count reach DEBOUNCE.
                    level  <= s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end
        end

        // Only the low-to-high transition of the accepted level is an event.
        assign press[g] = level & ~level_q;
    end

    logic ss_press;
    logic clr_press;

    assign ss_press  = press[0];
    assign clr_press = press[1];

    state_t        state;
    state_t        state_nxt;
    logic          clr_nxt;
    logic [PW-1:0] presc;

    always_comb begin
        state_nxt = state;
        clr_nxt   = 1'b0;
        case (state)
            IDLE: begin
                // Clear has priority over start when both arrive together.
                if (clr_press) begin
                    clr_nxt = 1'b1;
                end else if (ss_press) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Clear is not honoured while running.
                if (ss_press) begin
                    state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (clr_press) begin
                    state_nxt = IDLE;
                    clr_nxt   = 1'b1;
                end else if (ss_press) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            clr     <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr     <= clr_nxt;
            running <= (state_nxt == RUN);
        end
    end

    // Combinational so it drops the instant reset asserts (state goes IDLE).
    assign enable = (state == RUN) && (presc == PRESC_LAST);

    // Counts on every edge spent in RUN, including the edge that leaves RUN,
    // and holds in PAUSE so the partial tenth survives a pause.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (state_nxt == IDLE) begin
            presc <= '0;
        end else if (state == RUN) begin
            if (enable) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_control.sv
module tb_stopwatch_control;

    localparam int CLK_DIV  = 5;
    localparam int DEBOUNCE = 4;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic btn_ss  = 1'b0;
    logic btn_clr = 1'b0;
    logic enable;
    logic clr;
    logic running;

    int total = 0;
    int bad   = 0;

    stopwatch_control #(
        .CLK_DIV (CLK_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_ss (btn_ss),
        .btn_clr(btn_clr),
        .enable (enable),
        .clr    (clr),
        .running(running)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s at k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k, input logic e_en, input logic e_clr,
                           input logic e_run);
        chk({tag, ".enable"}, k, enable, e_en);
        chk({tag, ".clr"}, k, clr, e_clr);
        chk({tag, ".running"}, k, running, e_run);
    endtask

    // Edges (k = spec edge index, edge 0 = first edge after the first press is driven)
    // after which enable must be high in the main sequence.
    int en_list[$] = '{10, 15, 20, 25,
                       48, 53, 58, 63, 68, 73, 78, 83,
                       120, 125, 130, 135,
                       180};

    logic [15:0] bounce_pat = 16'b0000_0000_0111_0111;

    initial begin
        bit e_en;
        bit e_run;
        bit e_clr;

        // ---- Reset held low with buttons toggling -------------------------
        #1 reset = 1'b0;
        #1;
        chk_all("reset_assert", -1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            btn_ss  = ~btn_ss;
            btn_clr = ~btn_clr;
            step();
            chk_all("reset_hold", i, 1'b0, 1'b0, 1'b0);
        end
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        reset   = 1'b1;

        // ---- Bounce: 3 high, 1 low, 3 high, then low; never accepted ------
        for (int i = 0; i < 16; i++) begin
            btn_ss = bounce_pat[i];
            step();
            chk_all("bounce", i, 1'b0, 1'b0, 1'b0);
        end

        // ---- Main sequence ------------------------------------------------
        // start (RUN @6), pause @28 with prescaler 2, resume @46 (first tick @48),
        // clear ignored in RUN (@61), pause @86, clear in PAUSE @101,
        // restart @116 (tick @120), pause @136, simultaneous ss+clr @156,
        // restart @176 (tick @180).
        btn_ss = 1'b1;
        for (int k = 0; k <= 180; k++) begin
            step();
            e_run = (k >= 6 && k <= 27) || (k >= 46 && k <= 85) ||
                    (k >= 116 && k <= 135) || (k >= 176);
            e_clr = (k == 101) || (k == 156);
            e_en  = 1'b0;
            foreach (en_list[i]) begin
                if (en_list[i] == k) e_en = 1'b1;
            end
            chk_all("main", k, e_en, e_clr, e_run);

            case (k)
                21, 39, 79, 109, 129, 149, 169: btn_ss = 1'b1;
                9, 31, 49, 89, 119, 139, 159, 179: btn_ss = 1'b0;
                default: ;
            endcase
            case (k)
                54, 94, 149: btn_clr = 1'b1;
                64, 104, 159: btn_clr = 1'b0;
                default: ;
            endcase
        end

        // ---- Async reset in a cycle where enable is high ------------------
        reset  = 1'b0;
        btn_ss = 1'b1;
        #2;
        chk_all("reset_midrun", 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("reset_midrun_hold", i, 1'b0, 1'b0, 1'b0);
        end

        // ---- Button held through reset release acts as a fresh press ------
        reset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            chk_all("held_through_reset", n, 1'b0, 1'b0, n >= 6);
        end
        btn_ss = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
